// File: rtl/display_processor.sv
// display_processor: command-driven palette loader and framebuffer filler.
// Loads a default palette after reset, then fills the framebuffer on command.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   status_o    : [0] busy, [1] palette_ready, [2] fill_done, [31:16] fill count
//   control_i   : [0] fill start (edge), [1] pattern mode, [2] palette reload
//                 (edge), [15:8] fill index
//   fb_wr_*     : framebuffer write stream (x, y, index, strobe)
//   palette_wr_*: palette write stream (index, color, strobe)
//
// Build option: define DISPLAY_PROCESSOR_PATTERN_EN to enable the XOR pattern
// fill selected by control_i[1]; otherwise every fill is solid.

module display_processor #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int IW = $clog2(PALETTE_LENGTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic [31:0]           status_o,
    input  logic [31:0]           control_i,
    output logic [XW-1:0]         fb_wr_x_o,
    output logic [YW-1:0]         fb_wr_y_o,
    output logic [IW-1:0]         fb_wr_index_o,
    output logic                  fb_wr_en_o,
    output logic [IW-1:0]         palette_wr_index_o,
    output logic [COLOR_BITS-1:0] palette_wr_color_o,
    output logic                  palette_wr_en_o
);

    localparam logic [XW-1:0] X_LAST = XW'(RESOLUTION_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(RESOLUTION_Y - 1);
    localparam logic [IW-1:0] I_LAST = IW'(PALETTE_LENGTH - 1);

    typedef enum logic [1:0] {
        RESET_STATE,
        PAL,
        IDLE,
        FILL
    } state_t;

    state_t          state;
    logic            start_q;
    logic            reload_q;
    logic            busy_q;
    logic            ready_q;
    logic            done_q;
    logic [15:0]     count_q;
    logic [IW-1:0]   fill_idx_q;

    logic            start_edge;
    logic            reload_edge;
    logic            first_px;
    logic            at_x_last;
    logic            last_px;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;
    logic [IW-1:0]   pix_next;

    // Index replicated MSB-first across the color word.
    function automatic logic [COLOR_BITS-1:0] pal_color(input logic [IW-1:0] i);
        logic [COLOR_BITS-1:0] c;
        c = '0;
        for (int b = 0; b < COLOR_BITS; b++) begin
            c[COLOR_BITS-1-b] = i[IW-1-(b % IW)];
        end
        return c;
    endfunction

    assign start_edge  = control_i[0] & ~start_q;
    assign reload_edge = control_i[2] & ~reload_q;

    // Strobe low in FILL means the scan has not started: next pixel is (0,0).
    assign first_px  = ~fb_wr_en_o;
    assign at_x_last = (fb_wr_x_o == X_LAST);
    assign last_px   = ~first_px & at_x_last & (fb_wr_y_o == Y_LAST);

    always_comb begin
        nx = '0;
        ny = '0;
        if (!first_px) begin
            if (at_x_last) begin
                ny = fb_wr_y_o + YW'(1);
            end else begin
                nx = fb_wr_x_o + XW'(1);
                ny = fb_wr_y_o;
            end
        end
    end

`ifdef DISPLAY_PROCESSOR_PATTERN_EN
    localparam int XYW = (XW > YW) ? XW : YW;
    localparam int PW  = (XYW > IW) ? XYW : IW;

    logic            pattern_q;
    logic [PW-1:0]   pat_full;

    assign pat_full = PW'(nx) ^ PW'(ny);
    assign pix_next = pattern_q ? pat_full[IW-1:0] : fill_idx_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pattern_q <= 1'b0;
        end else if (state == IDLE && start_edge && !reload_edge) begin
            pattern_q <= control_i[1];
        end
    end

    logic unused_ctrl;
    assign unused_ctrl = ^{control_i[31:16], control_i[7:3]};
`else
    assign pix_next = fill_idx_q;

    logic unused_ctrl;
    assign unused_ctrl = ^{control_i[31:16], control_i[7:3], control_i[1]};
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state              <= RESET_STATE;
            start_q            <= 1'b0;
            reload_q           <= 1'b0;
            busy_q             <= 1'b0;
            ready_q            <= 1'b0;
            done_q             <= 1'b0;
            count_q            <= '0;
            fill_idx_q         <= '0;
            fb_wr_x_o          <= '0;
            fb_wr_y_o          <= '0;
            fb_wr_index_o      <= '0;
            fb_wr_en_o         <= 1'b0;
            palette_wr_index_o <= '0;
            palette_wr_color_o <= '0;
            palette_wr_en_o    <= 1'b0;
        end else begin
            start_q  <= control_i[0];
            reload_q <= control_i[2];
            unique case (state)
                RESET_STATE: begin
                    state              <= PAL;
                    busy_q             <= 1'b1;
                    palette_wr_en_o    <= 1'b1;
                    palette_wr_index_o <= '0;
                    palette_wr_color_o <= pal_color(IW'(0));
                end
                PAL: begin
                    if (palette_wr_index_o == I_LAST) begin
                        state           <= IDLE;
                        busy_q          <= 1'b0;
                        ready_q         <= 1'b1;
                        palette_wr_en_o <= 1'b0;
                    end else begin
                        palette_wr_index_o <= palette_wr_index_o + IW'(1);
                        palette_wr_color_o <= pal_color(palette_wr_index_o + IW'(1));
                    end
                end
                IDLE: begin
                    // Reload has priority over a simultaneous fill start.
                    if (reload_edge) begin
                        state              <= PAL;
                        busy_q             <= 1'b1;
                        palette_wr_en_o    <= 1'b1;
                        palette_wr_index_o <= '0;
                        palette_wr_color_o <= pal_color(IW'(0));
                    end else if (start_edge) begin
                        state      <= FILL;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        fill_idx_q <= IW'(control_i[15:8]);
                    end
                end
                FILL: begin
                    if (last_px) begin
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        count_q    <= count_q + 16'd1;
                        fb_wr_en_o <= 1'b0;
                    end else begin
                        fb_wr_en_o    <= 1'b1;
                        fb_wr_x_o     <= nx;
                        fb_wr_y_o     <= ny;
                        fb_wr_index_o <= pix_next;
                    end
                end
            endcase
        end
    end

    assign status_o = {count_q, 13'd0, done_q, ready_q, busy_q};

endmodule

// File: tb/tb_display_processor.sv
// Directed testbench for display_processor.
// Uses a reduced 320x12 framebuffer so each fill is 3840 pixels.

module tb_display_processor;

    localparam int RX  = 320;
    localparam int RY  = 12;
    localparam int PIX = RX * RY;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] control_i;
    logic [31:0] status_o;
    logic [8:0]  fb_x;
    logic [3:0]  fb_y;
    logic [7:0]  fb_idx;
    logic        fb_en;
    logic [7:0]  pal_idx;
    logic [11:0] pal_col;
    logic        pal_en;

    display_processor #(
        .RESOLUTION_X   (RX),
        .RESOLUTION_Y   (RY),
        .PALETTE_LENGTH (256),
        .COLOR_BITS     (12)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .status_o           (status_o),
        .control_i          (control_i),
        .fb_wr_x_o          (fb_x),
        .fb_wr_y_o          (fb_y),
        .fb_wr_index_o      (fb_idx),
        .fb_wr_en_o         (fb_en),
        .palette_wr_index_o (pal_idx),
        .palette_wr_color_o (pal_col),
        .palette_wr_en_o    (pal_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stream monitor state
    int          pal_cnt = 0;
    int          pal_bad = 0;
    int          fb_cnt = 0;
    int          fill_n = 0;
    int          coord_bad = 0;
    int          idx_bad = 0;
    int          both_hi = 0;
    int          last_x = -1;
    int          last_y = -1;
    logic        prev_fb_en = 1'b0;
    logic [11:0] col_a5 = 12'h000;
    logic [7:0]  px53 = 8'hFF;
    logic [7:0]  px300 = 8'hFF;

    logic        exp_pat;
    logic [7:0]  exp_solid;
    logic        capture;

    int          n_cur;
    int          ex;
    int          ey;
    logic [7:0]  pe;
    logic [11:0] pe_col;
    logic [8:0]  xy_x;
    logic [7:0]  e_idx;

    assign n_cur  = prev_fb_en ? fill_n : 0;
    assign ex     = n_cur % RX;
    assign ey     = n_cur / RX;
    assign pe     = pal_cnt[7:0];
    assign pe_col = {pe, pe[7:4]};
    assign xy_x   = fb_x ^ {5'd0, fb_y};
    assign e_idx  = exp_pat ? xy_x[7:0] : exp_solid;

    always @(negedge clk) begin
        if (pal_en && fb_en) both_hi <= both_hi + 1;
        if (pal_en) begin
            if (pal_idx !== pe || pal_col !== pe_col) pal_bad <= pal_bad + 1;
            if (pal_idx == 8'hA5) col_a5 <= pal_col;
            pal_cnt <= pal_cnt + 1;
        end
        if (fb_en) begin
            if (int'(fb_x) != ex || int'(fb_y) != ey) coord_bad <= coord_bad + 1;
            if (fb_idx !== e_idx) idx_bad <= idx_bad + 1;
            if (capture && fb_x == 9'd5 && fb_y == 4'd3) px53 <= fb_idx;
            if (capture && fb_x == 9'd300 && fb_y == 4'd10) px300 <= fb_idx;
            last_x <= int'(fb_x);
            last_y <= int'(fb_y);
            fill_n <= n_cur + 1;
            fb_cnt <= fb_cnt + 1;
        end
        prev_fb_en <= fb_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (status_o[0] && n < limit) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(n < limit), 32'd1);
    endtask

    int fb_before;
    int n_wait;

    initial begin
        reset_i   = 1'b1;
        control_i = 32'd0;
        exp_pat   = 1'b0;
        exp_solid = 8'd0;
        capture   = 1'b0;

        #12;
        chk("rst_status", status_o, 32'd0);
        chk("rst_fb_en", 32'(fb_en), 32'd0);
        chk("rst_pal_en", 32'(pal_en), 32'd0);
        chk("rst_pal_idx", 32'(pal_idx), 32'd0);
        chk("rst_fb_xy", {fb_x, fb_y, fb_idx}, 32'd0);
        #10;
        reset_i = 1'b0;

        @(negedge clk);
        chk("pal_first_en", 32'(pal_en), 32'd1);
        chk("pal_first_idx", 32'(pal_idx), 32'd0);
        chk("pal_busy", status_o, 32'h1);
        repeat (500) @(negedge clk);
        #1;
        chk("pal_count", pal_cnt, 256);
        chk("pal_stream", pal_bad, 0);
        chk("pal_a5", 32'(col_a5), 32'hA5A);
        chk("pal_status", status_o, 32'h2);
        chk("pal_no_fb", fb_cnt, 0);

        // Solid fill with index 7
        exp_pat   = 1'b0;
        exp_solid = 8'd7;
        control_i = 32'h0000_0701;
        @(negedge clk);
        chk("fill_start_status", status_o, 32'h3);
        chk("fill_start_noen", 32'(fb_en), 32'd0);
        control_i = 32'd0;
        @(negedge clk);
        chk("fill_first", {23'd0, fb_en, fb_x}, 32'h200);
        chk("fill_first_y_idx", {fb_y, fb_idx}, {20'd0, 4'd0, 8'd7});
        wait_idle("fill1_timeout", PIX + 20);
        chk("fill1_run", fill_n, PIX);
        chk("fill1_total", fb_cnt, PIX);
        chk("fill1_last", (last_x << 8) | last_y, (319 << 8) | 11);
        chk("fill1_coord", coord_bad, 0);
        chk("fill1_idx", idx_bad, 0);
        chk("fill1_status", status_o, 32'h0001_0006);

        // Pattern fill (solid index 0 when the pattern build is off)
`ifdef DISPLAY_PROCESSOR_PATTERN_EN
        exp_pat = 1'b1;
`else
        exp_pat = 1'b0;
`endif
        exp_solid = 8'd0;
        capture   = 1'b1;
        control_i = 32'h0000_0003;
        @(negedge clk);
        control_i = 32'd0;
        wait_idle("fill2_timeout", PIX + 20);
        capture = 1'b0;
`ifdef DISPLAY_PROCESSOR_PATTERN_EN
        chk("pat_5_3", 32'(px53), 32'h06);
        chk("pat_300_10", 32'(px300), 32'h26);
`else
        chk("pat_5_3", 32'(px53), 32'h00);
        chk("pat_300_10", 32'(px300), 32'h00);
`endif
        chk("fill2_idx", idx_bad, 0);
        chk("fill2_run", fill_n, PIX);
        chk("fill2_status", status_o, 32'h0002_0006);

        // Start and reload edges arriving mid-fill are discarded
        exp_pat   = 1'b0;
        exp_solid = 8'h2A;
        fb_before = fb_cnt;
        control_i = 32'h0000_2A01;
        @(negedge clk);
        control_i = 32'd0;
        repeat (100) @(negedge clk);
        control_i = 32'h0000_2A05;
        wait_idle("fill3_timeout", PIX + 20);
        chk("fill3_run", fill_n, PIX);
        chk("fill3_total", fb_cnt - fb_before, PIX);
        chk("fill3_no_reload", pal_cnt, 256);
        chk("fill3_idx", idx_bad, 0);
        chk("fill3_status", status_o, 32'h0003_0006);
        repeat (5) @(negedge clk);
        chk("fill3_no_restart", status_o, 32'h0003_0006);
        control_i = 32'd0;
        @(negedge clk);

        // Both edges together in IDLE: reload wins
        fb_before = fb_cnt;
        control_i = 32'h0000_0705;
        @(negedge clk);
        chk("both_busy", status_o, 32'h0003_0007);
        chk("both_pal_en", {pal_en, pal_idx}, 32'h100);
        control_i = 32'd0;
        wait_idle("reload_timeout", 300);
        chk("reload_count", pal_cnt, 512);
        chk("reload_no_fill", fb_cnt - fb_before, 0);
        chk("reload_status", status_o, 32'h0003_0006);

        // Reset in the middle of a fill
        exp_solid = 8'h55;
        control_i = 32'h0000_5501;
        @(negedge clk);
        control_i = 32'd0;
        n_wait = 0;
        while (fill_n < 1000 && n_wait < 2000) begin
            @(negedge clk);
            n_wait++;
        end
        chk("mid_reach", 32'(fill_n >= 1000), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_status", status_o, 32'd0);
        chk("mid_rst_fb", {fb_en, fb_x, fb_y, fb_idx}, 32'd0);
        chk("mid_rst_pal", {pal_en, pal_idx, pal_col}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        chk("mid_pal_count", pal_cnt, 768);
        chk("mid_status", status_o, 32'h2);
        chk("pal_stream_all", pal_bad, 0);
        chk("one_strobe", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_processor.md
# display_processor

Command-driven pixel/palette writer between the CPU-facing control/status registers and the framebuffer and palette RAMs. After reset it loads a default palette. On command it fills the whole framebuffer with a solid palette index or a generated pattern, one pixel per clock. It only produces write streams; it never reads either RAM.

## Interface
- RESOLUTION_X, 400, framebuffer width in pixels
- RESOLUTION_Y, 300, framebuffer height in pixels
- PALETTE_LENGTH, 256, palette entries (power of two, ≥2)
- COLOR_BITS, 12, palette color width
- Derived: XW=$clog2(RESOLUTION_X), YW=$clog2(RESOLUTION_Y), IW=$clog2(PALETTE_LENGTH)

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- status_o  out  32  [0] busy, [1] palette_ready, [2] fill_done (sticky), [15:3] 0, [31:16] completed-fill count
- control_i  in  32  [0] fill start (rising edge), [1] pattern mode, [2] palette reload (rising edge), [15:8] fill index, others ignored
- fb_wr_x_o  out  XW  pixel column
- fb_wr_y_o  out  YW  pixel row
- fb_wr_index_o  out  IW  palette index written to the pixel
- fb_wr_en_o  out  1  framebuffer write strobe
- palette_wr_index_o  out  IW  palette entry address
- palette_wr_color_o  out  COLOR_BITS  palette color
- palette_wr_en_o  out  1  palette write strobe

## Operation
- FSM states:
  - RESET_STATE while reset_i is high.
  - PAL: palette load.
  - IDLE.
  - FILL: framebuffer fill.
- After reset the FSM enters PAL unconditionally.
- PAL writes entries i = 0..PALETTE_LENGTH-1, one per cycle, then goes to IDLE and sets palette_ready.
  - The color for entry i is index i replicated MSB-first and truncated to the top COLOR_BITS bits. For the defaults this is {i[7:0], i[7:4]}, e.g. i=0xA5 gives 0xA5A.
- control_i[0] and control_i[2] are edge-detected against a previous-value register that resets to 0. A bit held high through reset therefore counts as an edge at the first sample.
- Edges are acted on only in IDLE. Edges arriving in PAL or FILL are discarded.
- Both edges in the same IDLE cycle: palette reload wins and the fill is dropped.
- Fill start:
  - Latch control_i[15:8] (truncated or zero-extended to IW) and control_i[1]. Clear fill_done. Enter FILL.
  - Scan order is row-major: x 0..RESOLUTION_X-1 within each y 0..RESOLUTION_Y-1.
  - Solid mode: index = latched value.
  - Pattern mode: index = (x XOR y) mod PALETTE_LENGTH.
  - After pixel (RESOLUTION_X-1, RESOLUTION_Y-1): return to IDLE, set fill_done, increment the count (16-bit, wraps 0xFFFF→0).
- Palette reload re-runs PAL. palette_ready stays 1 once set.
- busy = state is PAL or FILL.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including status_o, all counters and all strobes.
- Reset release:
  - First rising edge after reset_i falls: palette_wr_en_o=1, index 0.
  - Index N is presented on edge N+1.
  - Edge PALETTE_LENGTH+1: strobe drops, busy=0, palette_ready=1.
- Fill:
  - Edge sampling the start edge: busy=1, fill_done=0.
  - Next edge: fb_wr_en_o=1 at (0,0).
  - The strobe stays high for exactly RESOLUTION_X*RESOLUTION_Y consecutive cycles.
  - Following edge: strobe low, busy=0, fill_done=1, count+1.
- At most one strobe is high in any cycle.
- Addresses and data are don't-care while their strobe is low; they hold their last value.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). On release the full palette load restarts and the fill is abandoned with no count increment.

## Configuration
- DISPLAY_PROCESSOR_PATTERN_EN
  - Defined: control_i[1] selects pattern mode as described above.
  - Undefined: control_i[1] is ignored and every fill is solid. The XOR generator is not built.

## Test plan
- Reset 22 ns with control_i=0, run 500 cycles:
  - palette_wr_en_o high for exactly 256 cycles with indices 0..255 and entry 0xA5 = 0xA5A.
  - Then status_o=0x00000002; no fb writes.
- After the palette load, pulse control_i to 0x00000701 (fill index 7):
  - 120000 consecutive fb writes, all index 7, first at (0,0), last at (399,299).
  - status_o ends at 0x00010006.
- With DISPLAY_PROCESSOR_PATTERN_EN, control_i=0x00000003:
  - Pixel (5,3) gets index 6; pixel (300,10) gets index 0x26.
  - Without the macro, every pixel gets index 0.
- Raise control_i[0] and control_i[2] mid-fill:
  - Both ignored; the fill count increments exactly once.
- Raise control_i[0] and control_i[2] together in IDLE:
  - A 256-entry palette reload runs; no fill starts.
- Assert reset_i mid-fill at pixel ~1000:
  - All outputs are 0 during reset.
  - After release: palette reload, count 0, fill_done 0.
